// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: one holding slot per functional unit, round-robin
// selection of a held result, registered broadcast of the winner.
module cdb_arbiter #(
  parameter int NUM_REQ        = 3,
  parameter int DATA_WIDTH     = 32,
  parameter int ROB_IDX_WIDTH  = 5,
  parameter int REG_ADDR_WIDTH = 5,
  parameter int CNT_WIDTH      = 16
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               flush,
  input  logic [NUM_REQ-1:0]                 req_valid,
  output logic [NUM_REQ-1:0]                 req_ready,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]      req_data,
  input  logic [NUM_REQ*REG_ADDR_WIDTH-1:0]  req_rd_addr,
  input  logic [NUM_REQ*ROB_IDX_WIDTH-1:0]   req_rob_idx,
  input  logic [NUM_REQ-1:0]                 req_regf_we,
  output logic                               cdb_valid,
  output logic [DATA_WIDTH-1:0]              cdb_data,
  output logic [REG_ADDR_WIDTH-1:0]          cdb_rd_addr,
  output logic [ROB_IDX_WIDTH-1:0]           cdb_rob_idx,
  output logic                               cdb_regf_we,
  output logic [$clog2(NUM_REQ)-1:0]         cdb_src,
  output logic [CNT_WIDTH-1:0]               conflict_cnt
);

  localparam int SRC_W = $clog2(NUM_REQ);
  localparam int PW    = SRC_W + 1;

  // Per-unit views of the packed request buses
  logic [DATA_WIDTH-1:0]     in_data    [NUM_REQ];
  logic [REG_ADDR_WIDTH-1:0] in_rd_addr [NUM_REQ];
  logic [ROB_IDX_WIDTH-1:0]  in_rob_idx [NUM_REQ];

  // Holding slots
  logic [NUM_REQ-1:0]        hold_v_reg;
  logic [NUM_REQ-1:0]        hold_v_next;
  logic [DATA_WIDTH-1:0]     slot_data_reg [NUM_REQ];
  logic [REG_ADDR_WIDTH-1:0] slot_rd_reg   [NUM_REQ];
  logic [ROB_IDX_WIDTH-1:0]  slot_rob_reg  [NUM_REQ];
  logic [NUM_REQ-1:0]        slot_we_reg;

  // Arbitration
  logic [SRC_W-1:0]          rr_ptr_reg;
  logic [SRC_W-1:0]          rr_ptr_next;
  logic [NUM_REQ-1:0]        grant;
  logic                      any_grant;
  logic [SRC_W-1:0]          grant_idx;
  logic [PW-1:0]             cand;
  logic [NUM_REQ-1:0]        accept;
  logic                      multi_held;

  // Broadcast registers
  logic                      cdb_valid_reg;
  logic [DATA_WIDTH-1:0]     cdb_data_reg;
  logic [REG_ADDR_WIDTH-1:0] cdb_rd_reg;
  logic [ROB_IDX_WIDTH-1:0]  cdb_rob_reg;
  logic                      cdb_we_reg;
  logic [SRC_W-1:0]          cdb_src_reg;
  logic [CNT_WIDTH-1:0]      conflict_cnt_reg;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
      assign in_data[gi]    = req_data[gi*DATA_WIDTH +: DATA_WIDTH];
      assign in_rd_addr[gi] = req_rd_addr[gi*REG_ADDR_WIDTH +: REG_ADDR_WIDTH];
      assign in_rob_idx[gi] = req_rob_idx[gi*ROB_IDX_WIDTH +: ROB_IDX_WIDTH];
      // A slot being granted this cycle frees up in time to take a new result
      assign req_ready[gi]  = !rst && !flush && (!hold_v_reg[gi] || grant[gi]);
      assign accept[gi]     = req_valid[gi] && req_ready[gi];
    end
  endgenerate

  // Round-robin search starting at rr_ptr, wrapping past the last unit
  always_comb begin
    grant     = '0;
    any_grant = 1'b0;
    grant_idx = '0;
    cand      = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = {1'b0, rr_ptr_reg} + PW'(k);
      if (cand >= PW'(NUM_REQ)) begin
        cand = cand - PW'(NUM_REQ);
      end
      if (!any_grant && hold_v_reg[cand[SRC_W-1:0]]) begin
        any_grant                = 1'b1;
        grant[cand[SRC_W-1:0]]   = 1'b1;
        grant_idx                = cand[SRC_W-1:0];
      end
    end
  end

  // Two or more bits set: clearing the lowest set bit leaves something behind
  assign multi_held = (hold_v_reg & (hold_v_reg - NUM_REQ'(1))) != '0;

  always_comb begin
    hold_v_next = hold_v_reg;
    if (flush) begin
      hold_v_next = '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (accept[i]) begin
          hold_v_next[i] = 1'b1;
        end else if (grant[i]) begin
          hold_v_next[i] = 1'b0;
        end
      end
    end
  end

  always_comb begin
    rr_ptr_next = rr_ptr_reg;
    if (!flush && any_grant) begin
      rr_ptr_next = (grant_idx == SRC_W'(NUM_REQ - 1)) ? '0 : grant_idx + SRC_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hold_v_reg  <= '0;
      rr_ptr_reg  <= '0;
      slot_we_reg <= '0;
      for (int i = 0; i < NUM_REQ; i++) begin
        slot_data_reg[i] <= '0;
        slot_rd_reg[i]   <= '0;
        slot_rob_reg[i]  <= '0;
      end
    end else begin
      hold_v_reg <= hold_v_next;
      rr_ptr_reg <= rr_ptr_next;
      for (int i = 0; i < NUM_REQ; i++) begin
        if (accept[i]) begin
          slot_data_reg[i] <= in_data[i];
          slot_rd_reg[i]   <= in_rd_addr[i];
          slot_rob_reg[i]  <= in_rob_idx[i];
          slot_we_reg[i]   <= req_regf_we[i];
        end
      end
    end
  end

  // Idle cycles drive zeros on every field so consumers never see stale tags
  always_ff @(posedge clk) begin
    if (rst || flush || !any_grant) begin
      cdb_valid_reg <= 1'b0;
      cdb_data_reg  <= '0;
      cdb_rd_reg    <= '0;
      cdb_rob_reg   <= '0;
      cdb_we_reg    <= 1'b0;
      cdb_src_reg   <= '0;
    end else begin
      cdb_valid_reg <= 1'b1;
      cdb_data_reg  <= slot_data_reg[grant_idx];
      cdb_rd_reg    <= slot_rd_reg[grant_idx];
      cdb_rob_reg   <= slot_rob_reg[grant_idx];
      cdb_we_reg    <= slot_we_reg[grant_idx];
      cdb_src_reg   <= grant_idx;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      conflict_cnt_reg <= '0;
    end else if (!flush && multi_held && (conflict_cnt_reg != '1)) begin
      conflict_cnt_reg <= conflict_cnt_reg + CNT_WIDTH'(1);
    end
  end

  assign cdb_valid    = cdb_valid_reg;
  assign cdb_data     = cdb_data_reg;
  assign cdb_rd_addr  = cdb_rd_reg;
  assign cdb_rob_idx  = cdb_rob_reg;
  assign cdb_regf_we  = cdb_we_reg;
  assign cdb_src      = cdb_src_reg;
  assign conflict_cnt = conflict_cnt_reg;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter: inputs change on the falling edge, outputs
// are sampled on the falling edge, expectations are hand-computed constants.
module tb_cdb_arbiter;

  localparam int N  = 3;
  localparam int DW = 32;
  localparam int RW = 5;
  localparam int AW = 5;
  localparam int CW = 16;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            flush = 1'b0;
  logic [N-1:0]    req_valid = '0;
  logic [N-1:0]    req_ready;
  logic [N*DW-1:0] req_data = '0;
  logic [N*AW-1:0] req_rd_addr = '0;
  logic [N*RW-1:0] req_rob_idx = '0;
  logic [N-1:0]    req_regf_we = '0;
  logic            cdb_valid;
  logic [DW-1:0]   cdb_data;
  logic [AW-1:0]   cdb_rd_addr;
  logic [RW-1:0]   cdb_rob_idx;
  logic            cdb_regf_we;
  logic [1:0]      cdb_src;
  logic [CW-1:0]   conflict_cnt;

  int n_checks = 0;
  int n_pass   = 0;

  cdb_arbiter #(
    .NUM_REQ(N), .DATA_WIDTH(DW), .ROB_IDX_WIDTH(RW),
    .REG_ADDR_WIDTH(AW), .CNT_WIDTH(CW)
  ) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .req_valid(req_valid), .req_ready(req_ready), .req_data(req_data),
    .req_rd_addr(req_rd_addr), .req_rob_idx(req_rob_idx), .req_regf_we(req_regf_we),
    .cdb_valid(cdb_valid), .cdb_data(cdb_data), .cdb_rd_addr(cdb_rd_addr),
    .cdb_rob_idx(cdb_rob_idx), .cdb_regf_we(cdb_regf_we), .cdb_src(cdb_src),
    .conflict_cnt(conflict_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: observed timeout, expected $finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic chk_cdb(input string tag, input logic v, input logic [31:0] d,
                         input logic [4:0] rd, input logic [4:0] rob,
                         input logic we, input logic [1:0] src);
    chk({tag, ".valid"}, 64'(cdb_valid), 64'(v));
    chk({tag, ".data"},  64'(cdb_data), 64'(d));
    chk({tag, ".rd"},    64'(cdb_rd_addr), 64'(rd));
    chk({tag, ".rob"},   64'(cdb_rob_idx), 64'(rob));
    chk({tag, ".we"},    64'(cdb_regf_we), 64'(we));
    chk({tag, ".src"},   64'(cdb_src), 64'(src));
  endtask

  task automatic chk_idle(input string tag);
    chk_cdb(tag, 1'b0, 32'h0, 5'd0, 5'd0, 1'b0, 2'd0);
  endtask

  task automatic chk_ready(input string tag, input logic [2:0] exp);
    #1;
    chk(tag, 64'(req_ready), 64'(exp));
  endtask

  task automatic chk_cnt(input string tag, input logic [15:0] exp);
    chk(tag, 64'(conflict_cnt), 64'(exp));
  endtask

  task automatic put(input int i, input logic [31:0] d, input logic [4:0] rd,
                     input logic [4:0] rob, input logic we);
    req_valid[i]             = 1'b1;
    req_data[i*DW +: DW]     = d;
    req_rd_addr[i*AW +: AW]  = rd;
    req_rob_idx[i*RW +: RW]  = rob;
    req_regf_we[i]           = we;
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  initial begin
    // Reset state
    step(); step();
    chk_ready("rst_ready", 3'b000);
    chk_idle("rst_cdb");
    chk_cnt("rst_cnt", 16'h0);
    rst = 1'b0;
    chk_ready("post_rst_ready", 3'b111);

    // 1: single ALU result, visible two cycles after the handshake
    put(0, 32'h1234, 5'd3, 5'd7, 1'b1);
    step();
    req_valid = '0;
    chk("t1_c1_valid", 64'(cdb_valid), 64'(0));
    step();
    chk_cdb("t1_c2", 1'b1, 32'h1234, 5'd3, 5'd7, 1'b1, 2'd0);
    step();
    chk_idle("t1_c3");

    // Reset to bring rr_ptr back to 0
    rst = 1'b1;
    step();
    rst = 1'b0;

    // 2: all three units at once, LSU result with regf_we=0
    put(0, 32'hA0, 5'd1, 5'd1, 1'b1);
    put(1, 32'hB1, 5'd2, 5'd2, 1'b1);
    put(2, 32'hC2, 5'd4, 5'd3, 1'b0);
    step();
    req_valid = '0;
    chk_ready("t2_ready_a", 3'b001);
    chk_cnt("t2_cnt0", 16'd0);
    step();
    chk_cdb("t2_g0", 1'b1, 32'hA0, 5'd1, 5'd1, 1'b1, 2'd0);
    chk_ready("t2_ready_b", 3'b011);
    step();
    chk_cdb("t2_g1", 1'b1, 32'hB1, 5'd2, 5'd2, 1'b1, 2'd1);
    chk_cnt("t2_cnt_a", 16'd2);
    step();
    chk_cdb("t2_g2", 1'b1, 32'hC2, 5'd4, 5'd3, 1'b0, 2'd2);
    chk_cnt("t2_cnt_b", 16'd2);
    step();
    chk_idle("t2_idle");

    // 3: ALU and MUL streaming; grants alternate, nothing lost or repeated
    put(0, 32'h200, 5'd6, 5'd11, 1'b1);
    put(1, 32'h100, 5'd5, 5'd10, 1'b1);
    step();
    put(0, 32'h201, 5'd6, 5'd12, 1'b1);
    put(1, 32'h101, 5'd5, 5'd13, 1'b1);
    chk_ready("t3_ready_0", 3'b101);
    step();
    chk_cdb("t3_g0", 1'b1, 32'h200, 5'd6, 5'd11, 1'b1, 2'd0);
    put(0, 32'h202, 5'd6, 5'd14, 1'b1);
    chk_ready("t3_ready_1", 3'b110);
    step();
    chk_cdb("t3_g1", 1'b1, 32'h100, 5'd5, 5'd10, 1'b1, 2'd1);
    put(1, 32'h102, 5'd5, 5'd15, 1'b1);
    chk_ready("t3_ready_2", 3'b101);
    step();
    chk_cdb("t3_g2", 1'b1, 32'h201, 5'd6, 5'd12, 1'b1, 2'd0);
    put(0, 32'h203, 5'd6, 5'd16, 1'b1);
    chk_ready("t3_ready_3", 3'b110);
    step();
    chk_cdb("t3_g3", 1'b1, 32'h101, 5'd5, 5'd13, 1'b1, 2'd1);
    req_valid = '0;
    chk_ready("t3_ready_4", 3'b101);
    step();
    chk_cdb("t3_g4", 1'b1, 32'h202, 5'd6, 5'd14, 1'b1, 2'd0);
    chk_ready("t3_ready_5", 3'b111);
    step();
    chk_cdb("t3_g5", 1'b1, 32'h102, 5'd5, 5'd15, 1'b1, 2'd1);
    chk_cnt("t3_cnt", 16'd7);
    step();
    chk_idle("t3_idle");

    // 4: MUL held behind LSU refuses a second result and keeps the first
    put(1, 32'h300, 5'd7, 5'd20, 1'b1);
    put(2, 32'h400, 5'd8, 5'd21, 1'b1);
    step();
    req_valid[2] = 1'b0;
    put(1, 32'h333, 5'd7, 5'd22, 1'b1);
    chk_ready("t4_ready_held", 3'b101);
    step();
    chk_cdb("t4_g0", 1'b1, 32'h400, 5'd8, 5'd21, 1'b1, 2'd2);
    req_valid = '0;
    step();
    chk_cdb("t4_g1", 1'b1, 32'h300, 5'd7, 5'd20, 1'b1, 2'd1);
    chk_cnt("t4_cnt", 16'd8);
    step();
    chk_idle("t4_idle");

    // 5: flush drops two held results, leaves rr_ptr and the counter alone
    put(0, 32'h500, 5'd9, 5'd1, 1'b1);
    put(1, 32'h600, 5'd10, 5'd2, 1'b1);
    step();
    req_valid = '0;
    flush = 1'b1;
    chk_ready("t5_ready_flush", 3'b000);
    step();
    flush = 1'b0;
    chk_idle("t5_post_flush");
    chk_cnt("t5_cnt_hold", 16'd8);
    put(0, 32'h700, 5'd11, 5'd3, 1'b1);
    put(1, 32'h701, 5'd12, 5'd4, 1'b1);
    chk_ready("t5_ready_empty", 3'b111);
    step();
    req_valid = '0;
    chk("t5_no_stale", 64'(cdb_valid), 64'(0));
    step();
    chk_cdb("t5_g0", 1'b1, 32'h700, 5'd11, 5'd3, 1'b1, 2'd0);
    step();
    chk_cdb("t5_g1", 1'b1, 32'h701, 5'd12, 5'd4, 1'b1, 2'd1);
    chk_cnt("t5_cnt", 16'd9);
    step();
    chk_idle("t5_idle");

    // 6: reset with all slots held discards them
    put(0, 32'h800, 5'd1, 5'd1, 1'b1);
    put(1, 32'h801, 5'd2, 5'd2, 1'b1);
    put(2, 32'h802, 5'd3, 5'd3, 1'b1);
    step();
    req_valid = '0;
    rst = 1'b1;
    chk_ready("t6_ready_rst", 3'b000);
    step();
    rst = 1'b0;
    chk_idle("t6_rst_cdb");
    chk_cnt("t6_rst_cnt", 16'd0);
    chk_ready("t6_ready", 3'b111);
    step();
    chk_idle("t6_no_bcast");

    // Counter saturation with all three units streaming
    put(0, 32'h900, 5'd1, 5'd1, 1'b1);
    put(1, 32'h901, 5'd2, 5'd2, 1'b1);
    put(2, 32'h902, 5'd3, 5'd3, 1'b1);
    step();
    chk_cnt("sat_start", 16'd0);
    repeat (65534) step();
    chk_cnt("sat_fffe", 16'hFFFE);
    step();
    chk_cnt("sat_ffff", 16'hFFFF);
    repeat (3) step();
    chk_cnt("sat_hold", 16'hFFFF);
    req_valid = '0;
    step();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
